// File: rtl/capture_core.sv
// Input-capture core: measures clk-cycle distance between qualifying edges on capture_in.
// Optional glitch filter on the synchronized pin is enabled by defining CAPTURE_GLITCH_FILTER_EN.
module capture_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        single_shot,
    input  logic [1:0]  edge_sel,
    input  logic        capture_in,
    output logic        active,
    output logic        capture_valid,
    output logic [31:0] captured_value,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [31:0] r_count;
    logic        r_single;
    logic [1:0]  r_edge_sel;

    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic        w_accept;

`ifdef CAPTURE_GLITCH_FILTER_EN
    logic r_f1;
    logic r_f2;

    // r_s3 holds the previous filtered level, so it doubles as the filter's hold value.
    always_comb begin
        w_level = r_s3;
        if ((r_s2 == r_f1) && (r_f1 == r_f2)) begin
            w_level = r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f1 <= 1'b0;
            r_f2 <= 1'b0;
        end else begin
            r_f1 <= r_s2;
            r_f2 <= r_f1;
        end
    end
`else
    assign w_level = r_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= capture_in;
            r_s2 <= r_s1;
            r_s3 <= w_level;
        end
    end

    assign w_rise   = w_level & ~r_s3;
    assign w_fall   = ~w_level & r_s3;
    assign w_accept = (r_edge_sel == 2'b00) ? w_rise :
                      (r_edge_sel == 2'b01) ? w_fall : (w_rise | w_fall);

    // Priority inside each state: halt, then accepted edge, then overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= 32'd0;
            r_single       <= 1'b0;
            r_edge_sel     <= 2'b00;
            active         <= 1'b0;
            capture_valid  <= 1'b0;
            captured_value <= 32'd0;
            overflow       <= 1'b0;
        end else begin
            capture_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !halt) begin
                        r_state    <= S_ARMED;
                        r_single   <= single_shot;
                        r_edge_sel <= edge_sel;
                        overflow   <= 1'b0;
                        active     <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (halt) begin
                        r_state <= S_IDLE;
                        r_count <= 32'd0;
                        active  <= 1'b0;
                    end else if (w_accept) begin
                        r_state <= S_MEASURE;
                        r_count <= 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (halt) begin
                        r_state <= S_IDLE;
                        r_count <= 32'd0;
                        active  <= 1'b0;
                    end else if (w_accept) begin
                        captured_value <= r_count;
                        capture_valid  <= 1'b1;
                        if (r_single) begin
                            r_state <= S_IDLE;
                            r_count <= 32'd0;
                            active  <= 1'b0;
                        end else begin
                            r_count <= 32'd1;
                        end
                    end else if (r_count == 32'hFFFF_FFFF) begin
                        overflow <= 1'b1;
                        r_state  <= S_IDLE;
                        r_count  <= 32'd0;
                        active   <= 1'b0;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= 32'd0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule
